// File: rtl/serial_pkg.sv
// Shared types for the serial bitwise XOR/XNOR unit: FSM states, operating mode
// and the bit-index width helper.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic {
        MODE_XOR  = 1'b0,
        MODE_XNOR = 1'b1
    } mode_t;

    // A one-bit operand still needs a one-bit index register.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_engine.sv
// Single-bit evaluator: builds a[i] XOR b[i] from NOT/AND/OR over a 2-bit scratch
// store across the S0..S3 micro-steps, then applies the XNOR inversion.
module serial_bit_engine
    import serial_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  state_t i_step,
    input  logic   i_a_bit,
    input  logic   i_b_bit,
    input  mode_t  i_mode,
    output logic   o_r_bit
);

    logic r_m0;
    logic r_m1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m0 <= 1'b0;
            r_m1 <= 1'b0;
        end else begin
            case (i_step)
                S0:      r_m0 <= ~i_b_bit;
                S1:      r_m0 <= r_m0 & i_a_bit;
                S2:      r_m1 <= ~i_a_bit;
                default: ;
            endcase
        end
    end

    // m0 = a & ~b, m1 = ~a; (m1 & b) completes the other half of the XOR.
    assign o_r_bit = (r_m0 | (r_m1 & i_b_bit)) ^ logic'(i_mode);

endmodule

// File: rtl/serial_xor_n.sv
// Serial WIDTH-bit XOR/XNOR: latches operands on start, evaluates one bit per
// four-cycle micro-sequence LSB first, and presents the word with a done pulse.
//
//   state | meaning
//   IDLE  | waiting for start
//   S0    | m0 <= ~b[i]
//   S1    | m0 <= m0 & a[i]
//   S2    | m1 <= ~a[i]
//   S3    | r[i] <= result bit; advance index or finish
//   DONE  | one-cycle done pulse, y updated; start accepted here too
module serial_xor_n
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    localparam int            IW       = idx_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] w_r_merged;
    logic             w_accept;
    logic             w_last;
    logic             w_rbit;

    always_comb begin
        w_accept = start && ((r_state == IDLE) || (r_state == DONE));
        w_last   = (r_idx == LAST_IDX);
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? S0 : IDLE;
            S0:         w_next = S1;
            S1:         w_next = S2;
            S2:         w_next = S3;
            S3:         w_next = w_last ? DONE : S0;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The final bit is merged here so y can load in the same S3 edge.
    always_comb begin
        w_r_merged        = r_r;
        w_r_merged[r_idx] = w_rbit;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_mode <= MODE_XOR;
            r_r    <= '0;
            r_y    <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= a;
                r_b    <= b;
                r_mode <= mode_t'(mode);
                r_idx  <= '0;
            end
            if (r_state == S3) begin
                r_r <= w_r_merged;
                if (w_last) begin
                    r_y <= w_r_merged;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    serial_bit_engine u_engine (
        .clk     (clk),
        .rstn    (rstn),
        .i_step  (r_state),
        .i_a_bit (r_a[r_idx]),
        .i_b_bit (r_b[r_idx]),
        .i_mode  (r_mode),
        .o_r_bit (w_rbit)
    );

    assign busy = (r_state == S0) || (r_state == S1) ||
                  (r_state == S2) || (r_state == S3);
    assign done = (r_state == DONE);
    assign y    = r_y;

endmodule

// File: tb/tb_serial_xor_n.sv
// Directed bench for serial_xor_n: an 8-bit and a 1-bit instance share clock and reset.
module tb_serial_xor_n;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;

    logic       start8 = 1'b0;
    logic       mode8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] y8;

    logic       start1 = 1'b0;
    logic       mode1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [0:0] y1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_xor_n #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .y(y8)
    );

    serial_xor_n #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .mode(mode1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .y(y1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy8;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done1 : done8;
    endfunction

    function automatic logic [7:0] y_of(input bit sel);
        return sel ? {7'b0, y1} : y8;
    endfunction

    // Called at the first negedge after the accepting edge; returns at the done sample.
    task automatic wait_done(input bit sel, input string tag, output int lat, output int busy_cnt);
        int  k;
        bit  seen;
        k        = 1;
        busy_cnt = 0;
        while (!done_of(sel) && k < 200) begin
            if (busy_of(sel)) busy_cnt++;
            @(negedge clk);
            k++;
        end
        seen = done_of(sel);
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        lat = k - 1;
    endtask

    task automatic drive_start(input bit sel, input logic [7:0] a_v, input logic [7:0] b_v, input logic m);
        if (sel) begin
            start1 = 1'b1; a1 = a_v[0]; b1 = b_v[0]; mode1 = m;
        end else begin
            start8 = 1'b1; a8 = a_v; b8 = b_v; mode8 = m;
        end
    endtask

    task automatic run_op(input bit sel, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic m, input logic [7:0] exp_y, input string tag);
        int lat;
        int bc;
        int w4;
        w4 = sel ? 4 : 32;
        @(negedge clk);
        drive_start(sel, a_v, b_v, m);
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
        wait_done(sel, tag, lat, bc);
        check_val({tag, "_latency"}, 32'(lat), 32'(w4));
        check_val({tag, "_busy_cycles"}, 32'(bc), 32'(w4));
        check_val({tag, "_y"}, 32'(y_of(sel)), 32'(exp_y));
        @(negedge clk);
        check_val({tag, "_done_one_cycle"}, 32'(done_of(sel)), 32'd0);
        check_val({tag, "_y_held"}, 32'(y_of(sel)), 32'(exp_y));
    endtask

    initial begin
        int lat;
        int bc;
        int cnt;
        logic [7:0] tt;

        #1;
        check_val("rst_busy", 32'(busy8), 32'd0);
        check_val("rst_done", 32'(done8), 32'd0);
        check_val("rst_y", 32'(y8), 32'd0);
        check_val("rst_y1", 32'(y1), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_op(0, 8'hA5, 8'h3C, 1'b0, 8'h99, "xor_a5_3c");
        run_op(0, 8'hA5, 8'h3C, 1'b1, 8'h66, "xnor_a5_3c");
        run_op(0, 8'hFF, 8'hFF, 1'b0, 8'h00, "xor_ff_ff");
        run_op(0, 8'h00, 8'hFF, 1'b0, 8'hFF, "xor_00_ff");
        run_op(0, 8'hC3, 8'h0F, 1'b1, 8'h33, "xnor_c3_0f");

        // start held high with operands churning during busy
        @(negedge clk);
        drive_start(0, 8'h12, 8'h34, 1'b0);
        @(negedge clk);
        cnt = 1;
        bc  = 0;
        while (!done8 && cnt < 200) begin
            if (busy8) bc++;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            cnt++;
        end
        start8 = 1'b0;
        check_val("held_done_seen", 32'(done8), 32'd1);
        check_val("held_latency", 32'(cnt - 1), 32'd32);
        check_val("held_busy_cycles", 32'(bc), 32'd32);
        check_val("held_y", 32'(y8), 32'h26);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        check_val("held_extra_done", 32'(cnt), 32'd0);

        // back-to-back start in the DONE cycle
        @(negedge clk);
        drive_start(0, 8'hA5, 8'h3C, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        wait_done(0, "b2b_first", lat, bc);
        check_val("b2b_first_latency", 32'(lat), 32'd32);
        check_val("b2b_first_y", 32'(y8), 32'h99);
        drive_start(0, 8'h0F, 8'hF0, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        check_val("b2b_no_gap", 32'(busy8), 32'd1);
        check_val("b2b_y_hold", 32'(y8), 32'h99);
        wait_done(0, "b2b_second", lat, bc);
        check_val("b2b_done_spacing", 32'(lat + 1), 32'd33);
        check_val("b2b_second_y", 32'(y8), 32'hFF);
        @(negedge clk);

        // asynchronous reset in the middle of bit 3
        @(negedge clk);
        drive_start(0, 8'h33, 8'h55, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (13) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy8), 32'd0);
        check_val("midrst_done", 32'(done8), 32'd0);
        check_val("midrst_y", 32'(y8), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        check_val("midrst_no_done", 32'(cnt), 32'd0);
        run_op(0, 8'h5A, 8'h5A, 1'b1, 8'hFF, "post_rst_xnor");

        // WIDTH=1 truth table: index = {mode, b, a}
        tt = 8'h96;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op(1, {7'b0, v[0]}, {7'b0, v[1]}, v[2], {7'b0, tt[i]}, $sformatf("w1_case%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
